// File: rtl/proto_field_collector.sv
// Protobuf field collector: per-field slots gather (field number, value) beats into
// one message record, handed downstream through a single held output buffer.

module proto_field_slot #(
  parameter int DATA_W  = 64,
  parameter bit ZIGZAG  = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] val,
  output logic [DATA_W-1:0] rec_val,
  output logic              rec_present
);
  logic [DATA_W-1:0] dec;
  logic [DATA_W-1:0] acc_q;
  logic              pres_q;

  generate
    if (ZIGZAG) begin : g_zz
      // (v >> 1) ^ -(v & 1): the negated LSB is all-ones or all-zeros
      assign dec = (val >> 1) ^ {DATA_W{val[0]}};
    end else begin : g_raw
      assign dec = val;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i || clr) begin
      acc_q  <= '0;
      pres_q <= 1'b0;
    end else if (wr) begin
      acc_q  <= dec;
      pres_q <= 1'b1;
    end
  end

  // A beat arriving with msg_last belongs to the record being closed
  assign rec_val     = wr ? dec : acc_q;
  assign rec_present = wr | pres_q;
endmodule

module proto_field_collector #(
  parameter int                    NUM_FIELDS  = 8,
  parameter int                    DATA_W      = 64,
  parameter logic [NUM_FIELDS-1:0] ZIGZAG_MASK = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         field_valid_i,
  input  logic [4:0]                   field_num_i,
  input  logic [DATA_W-1:0]            field_val_i,
  input  logic                         msg_last_i,
  output logic                         msg_valid_o,
  input  logic                         msg_ready_i,
  output logic [NUM_FIELDS*DATA_W-1:0] msg_fields_o,
  output logic [NUM_FIELDS-1:0]        msg_present_o,
  output logic                         unknown_o,
  output logic                         overflow_o
);
  localparam logic [4:0] NF = 5'(NUM_FIELDS);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                              state_q, state_d;
  logic [NUM_FIELDS-1:0][DATA_W-1:0]   rec_val;
  logic [NUM_FIELDS-1:0]               rec_pres;
  logic [NUM_FIELDS-1:0][DATA_W-1:0]   out_val_q;
  logic [NUM_FIELDS-1:0]               out_pres_q;
  logic                                unk;
  logic                                load;
  logic                                ovf_set;
  logic                                ovf_q;
  logic                                unk_q;

  assign unk = field_valid_i && ((field_num_i == 5'd0) || (field_num_i > NF));

  generate
    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_slot
      proto_field_slot #(
        .DATA_W (DATA_W),
        .ZIGZAG (ZIGZAG_MASK[k])
      ) u_slot (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .wr          (field_valid_i && (field_num_i == 5'(k + 1))),
        .clr         (msg_last_i),
        .val         (field_val_i),
        .rec_val     (rec_val[k]),
        .rec_present (rec_pres[k])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      EMPTY: begin
        if (msg_last_i) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (msg_ready_i) begin
          // Accept and refill in the same cycle keeps the output busy
          if (msg_last_i) load = 1'b1;
          else            state_d = EMPTY;
        end else if (msg_last_i) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= EMPTY;
      out_val_q  <= '0;
      out_pres_q <= '0;
      ovf_q      <= 1'b0;
      unk_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_val_q  <= rec_val;
        out_pres_q <= rec_pres;
      end
      ovf_q <= ovf_q | ovf_set;
      unk_q <= unk;
    end
  end

  assign msg_valid_o   = (state_q == FULL);
  assign msg_fields_o  = out_val_q;
  assign msg_present_o = out_pres_q;
  assign unknown_o     = unk_q;
  assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_proto_field_collector.sv
// Scoreboard bench for proto_field_collector: a reference model predicts each
// accepted record, unknown pulses and overflow; directed cases then random traffic.

module tb_proto_field_collector;
  localparam int NF = 8;
  localparam int DW = 64;
  localparam logic [NF-1:0] ZZ = 8'b0000_0010;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              field_valid_i;
  logic [4:0]        field_num_i;
  logic [DW-1:0]     field_val_i;
  logic              msg_last_i;
  logic              msg_valid_o;
  logic              msg_ready_i;
  logic [NF*DW-1:0]  msg_fields_o;
  logic [NF-1:0]     msg_present_o;
  logic              unknown_o;
  logic              overflow_o;

  proto_field_collector #(.NUM_FIELDS(NF), .DATA_W(DW), .ZIGZAG_MASK(ZZ)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .field_valid_i (field_valid_i),
    .field_num_i   (field_num_i),
    .field_val_i   (field_val_i),
    .msg_last_i    (msg_last_i),
    .msg_valid_o   (msg_valid_o),
    .msg_ready_i   (msg_ready_i),
    .msg_fields_o  (msg_fields_o),
    .msg_present_o (msg_present_o),
    .unknown_o     (unknown_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NF-1:0][DW-1:0] f;
    logic [NF-1:0]         p;
  } rec_t;

  rec_t                  sb[$];
  logic [NF-1:0][DW-1:0] m_acc;
  logic [NF-1:0]         m_pres;
  logic                  m_full, m_ovf;
  int                    n_chk = 0;
  int                    n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] zz_model(input int n, input logic [DW-1:0] v);
    if (!ZZ[n-1]) return v;
    if (v[0]) return -((v >> 1) + 64'd1);
    return v >> 1;
  endfunction

  task automatic do_reset();
    reset_i = 1'b1; field_valid_i = 1'b0; field_num_i = '0; field_val_i = '0;
    msg_last_i = 1'b0; msg_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    m_acc = '0; m_pres = '0; m_full = 1'b0; m_ovf = 1'b0;
    sb.delete();
    chk("rst_valid", 64'(msg_valid_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_unk", 64'(unknown_o), 64'd0);
    chk("rst_pres", 64'(msg_present_o), 64'd0);
    chk("rst_fields_or", 64'(|msg_fields_o), 64'd0);
  endtask

  // One clock: drive, retire any handshake into the scoreboard, advance the model, check flags
  task automatic beat(input logic v, input logic [4:0] n, input logic [DW-1:0] val,
                      input logic last, input logic rdy);
    logic hs, unk;
    rec_t r;
    field_valid_i = v; field_num_i = n; field_val_i = val;
    msg_last_i = last; msg_ready_i = rdy;
    if (msg_valid_o && rdy) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        r = sb.pop_front();
        for (int k = 0; k < NF; k++)
          chk($sformatf("rec_f%0d", k + 1), msg_fields_o[k*DW +: DW], r.f[k]);
        chk("rec_pres", 64'(msg_present_o), 64'(r.p));
      end
    end
    hs  = m_full && rdy;
    unk = v && (n == 5'd0 || n > 5'(NF));
    if (v && !unk) begin
      m_acc[n-1]  = zz_model(int'(n), val);
      m_pres[n-1] = 1'b1;
    end
    if (last) begin
      if (!m_full || hs) begin
        r.f = m_acc; r.p = m_pres;
        sb.push_back(r);
        m_full = 1'b1;
      end else m_ovf = 1'b1;
      m_acc = '0; m_pres = '0;
    end else if (hs) m_full = 1'b0;
    @(posedge clk_i); #1;
    field_valid_i = 1'b0; msg_last_i = 1'b0;
    chk("valid", 64'(msg_valid_o), 64'(m_full));
    chk("unknown", 64'(unknown_o), 64'(unk));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  task automatic idle(input logic rdy);
    beat(1'b0, 5'd0, '0, 1'b0, rdy);
  endtask

  initial begin
    do_reset();

    // Basic record: fields 1 and 3, last beat carries field 3
    beat(1, 5'd1, 64'h05, 0, 0);
    beat(1, 5'd3, 64'h1234, 1, 0);
    chk("t1_pres", 64'(msg_present_o), 64'h05);
    chk("t1_f1", msg_fields_o[0 +: DW], 64'h05);
    chk("t1_f3", msg_fields_o[2*DW +: DW], 64'h1234);
    idle(1);

    // Zigzag on field 2 only
    beat(1, 5'd2, 64'd3, 0, 0);
    beat(1, 5'd1, 64'd3, 1, 0);
    chk("t2_f2_neg", msg_fields_o[DW +: DW], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_f1_raw", msg_fields_o[0 +: DW], 64'd3);
    beat(1, 5'd2, 64'd4, 1, 1);
    chk("t2_f2_pos", msg_fields_o[DW +: DW], 64'd2);
    idle(1);

    // Backpressure: B closes while A is held -> dropped, overflow sticky
    beat(1, 5'd1, 64'hA, 1, 0);
    beat(1, 5'd1, 64'hB, 1, 0);
    chk("t3_held_a", msg_fields_o[0 +: DW], 64'hA);
    idle(0);
    idle(1);
    chk("t3_ovf_sticky", 64'(overflow_o), 64'd1);

    // Accept A and commit B in the same cycle
    do_reset();
    beat(1, 5'd6, 64'hAA, 1, 0);
    beat(1, 5'd7, 64'hBB, 1, 1);
    chk("t4_b_f7", msg_fields_o[6*DW +: DW], 64'hBB);
    chk("t4_b_pres", 64'(msg_present_o), 64'h40);
    idle(1);

    // Unknown field numbers and last-write-wins
    beat(1, 5'd0, 64'h11, 0, 0);
    beat(1, 5'd9, 64'h22, 0, 0);
    beat(1, 5'd4, 64'd7, 0, 0);
    beat(1, 5'd4, 64'd9, 1, 0);
    chk("t5_f4", msg_fields_o[3*DW +: DW], 64'd9);
    chk("t5_pres", 64'(msg_present_o), 64'h08);
    idle(1);

    // Reset mid-message discards partial fields
    beat(1, 5'd1, 64'h1, 0, 0);
    beat(1, 5'd2, 64'h2, 0, 0);
    do_reset();
    beat(1, 5'd5, 64'h55, 1, 0);
    chk("t6_pres", 64'(msg_present_o), 64'h10);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] n;
      n = 5'($urandom_range(0, 10));
      beat(1'($urandom_range(0, 3) != 0), n, {$urandom, $urandom},
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    end
    repeat (3) idle(1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
